// File: rtl/rx_byte_fifo_pkg.sv
// Shared types and default parameters for the receive byte FIFO.
package rx_byte_fifo_pkg;

  localparam int unsigned RX_FIFO_DEPTH      = 16;
  localparam int unsigned RX_FIFO_DATA_WIDTH = 8;
  localparam int unsigned RX_FIFO_GAP_TICKS  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } rx_fifo_state_t;

endpackage

// File: rtl/rx_byte_fifo_fifo.sv
// Generic synchronous circular-buffer FIFO with registered level/empty/full.
// A pop is ignored when empty; a push at full is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   rd_data_c,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    empty,
  output logic                    full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic                  do_push_c;
  logic                  do_pop_c;
  logic [LW-1:0]         level_d;

  // Accept decisions; a same-cycle pop frees the slot a full push needs.
  always_comb begin
    do_pop_c  = pop && !empty;
    do_push_c = push && (!full || do_pop_c);
  end

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    level_d = level;
    case ({do_push_c, do_pop_c})
      2'b10:   level_d = level + LW'(1);
      2'b01:   level_d = level - LW'(1);
      default: level_d = level;
    endcase
  end

  // Pointers and registered status flags.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level <= level_d;
      empty <= (level_d == '0);
      full  <= (level_d == LW'(DEPTH));
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk_in) begin
    if (do_push_c) mem[wr_ptr_q] <= push_data;
  end

  assign rd_data_c = mem[rd_ptr_q];

endmodule

// File: rtl/rx_byte_fifo.sv
// Elastic receive buffer: re-issues buffered bytes to the controller as
// single-cycle pulses paced by its ready/busy handshake, flags dropped bytes.
module rx_byte_fifo
  import rx_byte_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = RX_FIFO_DEPTH,
  parameter int unsigned DATA_WIDTH = RX_FIFO_DATA_WIDTH,
  parameter int unsigned GAP_TICKS  = RX_FIFO_GAP_TICKS
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  input  logic                    ctrl_ready,
  input  logic                    ctrl_busy,
  input  logic                    clear_overflow,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_pulse,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    empty,
  output logic                    full,
  output logic                    overflow
);

  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  rx_fifo_state_t        state_q;
  rx_fifo_state_t        state_d;
  logic [GW-1:0]         gap_cnt_q;
  logic [GW-1:0]         gap_cnt_d;
  logic                  pop_c;
  logic                  drop_c;
  logic [DATA_WIDTH-1:0] rd_data_c;

  sync_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop_c),
    .rd_data_c (rd_data_c),
    .level     (level),
    .empty     (empty),
    .full      (full)
  );

  // Pacing FSM: pop in IDLE when the consumer can take a byte, then pulse and hold off.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pop_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && ctrl_ready && !ctrl_busy) begin
          pop_c   = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        state_d   = GAP;
        gap_cnt_d = GW'(GAP_TICKS - 1);
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A push is dropped only when full with no pop freeing a slot.
  always_comb begin
    drop_c = in_valid && full && !pop_c;
  end

  // FSM state, registered pulse/data outputs and sticky overflow.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      out_pulse <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      out_pulse <= (state_d == PRESENT);
      if (pop_c) out_data <= rd_data_c;
      if (drop_c)              overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule
